// File: rtl/athos_pkg.sv
// Shared ATHOS types: functional-unit result bundle and write-back sequencer types.
package athos_pkg;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
    } out_t;

    typedef enum logic [1:0] {DWR_IDLE, DWR_WR1, DWR_WR2} dwr_state_e;

    typedef struct packed {
        out_t       res;
        logic [4:0] a1, a2;
        logic       dw;
    } wb_req_t;

endpackage

// File: rtl/athos_dwrite_ctrl.sv
// Serialises one- or two-result ATHOS bundles onto the single register-file write port.
module athos_dwrite_ctrl
    import athos_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_dwrite_i,
    input  out_t              req_res_i,
    input  logic [ADDR_W-1:0] req_rd1_addr_i,
    input  logic [ADDR_W-1:0] req_rd2_addr_i,
    input  logic              flush_i,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    input  logic              rf_gnt_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  dwrite_cnt_o
);

    dwr_state_e        state_q, state_d;
    wb_req_t           hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic              slot_done, final_slot, accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign cur_addr   = (state_q == DWR_WR2) ? hold_q.a2 : hold_q.a1;
    assign cur_data   = (state_q == DWR_WR2) ? hold_q.res.rd2 : hold_q.res.rd1;

    // x0 slots retire immediately without touching the write port
    assign slot_done  = (state_q != DWR_IDLE) && (rf_gnt_i || (cur_addr == '0));
    assign final_slot = (state_q == DWR_WR2) || ((state_q == DWR_WR1) && !hold_q.dw);

    assign req_ready_o = !flush_i && ((state_q == DWR_IDLE) || (slot_done && final_slot));
    assign accept      = req_valid_i && req_ready_o;

    assign rf_we_o      = (state_q != DWR_IDLE) && (cur_addr != '0);
    assign rf_waddr_o   = (state_q != DWR_IDLE) ? cur_addr : '0;
    assign rf_wdata_o   = (state_q != DWR_IDLE) ? cur_data : '0;
    assign busy_o       = (state_q != DWR_IDLE);
    assign dwrite_cnt_o = cnt_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (flush_i) begin
            state_d = DWR_IDLE;
        end else if (accept) begin
            state_d       = DWR_WR1;
            hold_d.res    = req_res_i;
            hold_d.a1     = req_rd1_addr_i;
            hold_d.a2     = req_rd2_addr_i;
            hold_d.dw     = req_dwrite_i;
        end else if (slot_done) begin
            state_d = final_slot ? DWR_IDLE : DWR_WR2;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= DWR_IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            // second-slot completion counts even when flush arrives in the same cycle
            if ((state_q == DWR_WR2) && slot_done)
                cnt_q <= sat_inc(cnt_q);
        end
    end

endmodule

// File: tb/tb_athos_dwrite_ctrl.sv
// Directed bench for the ATHOS double-write sequencer.
module tb_athos_dwrite_ctrl;
    import athos_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, ready, dwrite, flush, we, gnt, busy;
    out_t        res;
    logic [4:0]  a1, a2, waddr;
    logic [31:0] wdata;
    logic [15:0] cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    athos_dwrite_ctrl #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(valid), .req_ready_o(ready), .req_dwrite_i(dwrite),
        .req_res_i(res), .req_rd1_addr_i(a1), .req_rd2_addr_i(a2),
        .flush_i(flush),
        .rf_we_o(we), .rf_waddr_o(waddr), .rf_wdata_o(wdata), .rf_gnt_i(gnt),
        .busy_o(busy), .dwrite_cnt_o(cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic dw, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [4:0] x1, input logic [4:0] x2);
        valid   = 1'b1;
        dwrite  = dw;
        res.rd1 = d1;
        res.rd2 = d2;
        a1      = x1;
        a2      = x2;
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; dwrite = 1'b0; flush = 1'b0; gnt = 1'b1;
        res = '0; a1 = '0; a2 = '0;
        tick; tick;
        @(negedge clk);
        chk("rst_we", we, 0);
        chk("rst_addr", waddr, 0);
        chk("rst_data", wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", cnt, 0);
        rst_n = 1'b1;

        // single write
        tick;
        set_req(1'b0, 32'hDEADBEEF, 32'h0, 5'd5, 5'd9);
        @(negedge clk);
        chk("t1_ready_idle", ready, 1);
        tick;
        valid = 1'b0;
        @(negedge clk);
        chk("t1_we", we, 1);
        chk("t1_addr", waddr, 5);
        chk("t1_data", wdata, 32'hDEADBEEF);
        tick;
        @(negedge clk);
        chk("t1_we_after", we, 0);
        chk("t1_busy_after", busy, 0);
        chk("t1_cnt", cnt, 0);

        // load64-style double write
        set_req(1'b1, 32'h87654321, 32'h11223344, 5'd10, 5'd11);
        tick;
        valid = 1'b0;
        @(negedge clk);
        chk("t2_wr1_addr", waddr, 10);
        chk("t2_wr1_data", wdata, 32'h87654321);
        chk("t2_wr1_ready", ready, 0);
        tick;
        @(negedge clk);
        chk("t2_wr2_we", we, 1);
        chk("t2_wr2_addr", waddr, 11);
        chk("t2_wr2_data", wdata, 32'h11223344);
        chk("t2_wr2_ready", ready, 1);
        tick;
        @(negedge clk);
        chk("t2_busy", busy, 0);
        chk("t2_cnt", cnt, 1);

        // three back-to-back double bundles, no bubbles
        set_req(1'b1, 32'h10000000, 32'h20000000, 5'd1, 5'd20);
        for (int i = 0; i < 3; i++) begin
            tick;
            if (i < 2)
                set_req(1'b1, 32'h10000001 + i, 32'h20000001 + i, 5'(i + 2), 5'(i + 21));
            else
                valid = 1'b0;
            @(negedge clk);
            chk("t3_wr1_we", we, 1);
            chk("t3_wr1_addr", waddr, i + 1);
            chk("t3_wr1_data", wdata, 32'h10000000 + i);
            tick;
            @(negedge clk);
            chk("t3_wr2_we", we, 1);
            chk("t3_wr2_addr", waddr, i + 20);
            chk("t3_wr2_data", wdata, 32'h20000000 + i);
        end
        tick;
        @(negedge clk);
        chk("t3_busy", busy, 0);
        chk("t3_we", we, 0);
        chk("t3_cnt", cnt, 4);

        // grant stalls in WR2
        set_req(1'b1, 32'hAAAA0001, 32'hBBBB0002, 5'd3, 5'd4);
        tick;
        valid = 1'b0;
        @(negedge clk);
        chk("t4_wr1_addr", waddr, 3);
        tick;
        gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_stall_we", we, 1);
            chk("t4_stall_addr", waddr, 4);
            chk("t4_stall_data", wdata, 32'hBBBB0002);
            chk("t4_stall_ready", ready, 0);
            tick;
        end
        gnt = 1'b1;
        @(negedge clk);
        chk("t4_gnt_ready", ready, 1);
        chk("t4_gnt_addr", waddr, 4);
        tick;
        @(negedge clk);
        chk("t4_busy", busy, 0);
        chk("t4_cnt", cnt, 5);

        // rd1 to x0: slot retires without grant
        gnt = 1'b0;
        set_req(1'b1, 32'hCAFE0000, 32'h0000BEEF, 5'd0, 5'd7);
        tick;
        valid = 1'b0;
        @(negedge clk);
        chk("t5_x0_we", we, 0);
        chk("t5_x0_busy", busy, 1);
        chk("t5_x0_ready", ready, 0);
        tick;
        gnt = 1'b1;
        @(negedge clk);
        chk("t5_wr2_we", we, 1);
        chk("t5_wr2_addr", waddr, 7);
        chk("t5_wr2_data", wdata, 32'h0000BEEF);
        tick;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_cnt", cnt, 6);

        // flush during WR1, with a valid bundle offered in the flush cycle
        gnt = 1'b0;
        set_req(1'b1, 32'h12121212, 32'h34343434, 5'd12, 5'd13);
        tick;
        @(negedge clk);
        chk("t6_wr1_addr", waddr, 12);
        flush = 1'b1;
        #1;
        chk("t6_flush_ready", ready, 0);
        tick;
        flush = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        chk("t6_flush_busy", busy, 0);
        chk("t6_flush_we", we, 0);
        chk("t6_flush_cnt", cnt, 6);

        // reset in the middle of WR2
        gnt = 1'b1;
        set_req(1'b1, 32'h55555555, 32'h66666666, 5'd14, 5'd15);
        tick;
        valid = 1'b0;
        tick;
        @(negedge clk);
        chk("t6_wr2_addr", waddr, 15);
        rst_n = 1'b0;
        tick;
        @(negedge clk);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_we", we, 0);
        chk("t6_rst_addr", waddr, 0);
        chk("t6_rst_data", wdata, 0);
        chk("t6_rst_cnt", cnt, 0);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
